// File: rtl/spi_adc_capture.sv
// rtl/spi_adc_capture.sv - triggered ADC conversion, MSB-first SPI readout and one-entry AXI4-Stream output
// Drops and counts triggers that arrive mid-conversion and samples that find the output register full.
module spi_adc_capture #(
   parameter int DATA_WIDTH = 24,
   parameter int CNV_CYCLES = 4,
   parameter int SCK_DIV    = 1
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  trigger_i,
   output logic                  cnv_o,
   output logic                  sck_o,
   input  logic                  sdo_i,
   output logic                  busy_o,
   output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
   output logic                  m_axis_tvalid_o,
   input  logic                  m_axis_tready_i,
   output logic [15:0]           overrun_count_o
);

   localparam int CNT_W = (CNV_CYCLES > 1) ? $clog2(CNV_CYCLES) : 1;
   localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
   localparam int BIT_W = $clog2(DATA_WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CONVERT,
      S_SHIFT,
      S_DONE
   } state_e;

   state_e                state_q, state_d;
   logic                  cnv_q, cnv_d;
   logic                  sck_q, sck_d;
   logic [CNT_W-1:0]      cnv_cnt_q, cnv_cnt_d;
   logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
   logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
   logic                  tvalid_q, tvalid_d;
   logic [15:0]           ovr_q, ovr_d;
   logic                  overrun_evt;

   logic conv_last, sck_tick, sck_fall, last_bit, out_free;

   assign conv_last = (cnv_cnt_q == '0);
   assign sck_tick  = (div_cnt_q == '0);
   assign sck_fall  = sck_tick && sck_q;
   assign last_bit  = (bit_cnt_q == BIT_W'(1));
   assign out_free  = !tvalid_q || m_axis_tready_i;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:    if (trigger_i) state_d = S_CONVERT;
         S_CONVERT: if (conv_last) state_d = S_SHIFT;
         S_SHIFT:   if (sck_fall && last_bit) state_d = S_DONE;
         S_DONE:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy_o      = (state_q != S_IDLE);
      cnv_d       = cnv_q;
      sck_d       = sck_q;
      cnv_cnt_d   = cnv_cnt_q;
      div_cnt_d   = div_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      tdata_d     = tdata_q;
      tvalid_d    = tvalid_q;
      overrun_evt = 1'b0;

      if (tvalid_q && m_axis_tready_i) tvalid_d = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (trigger_i) begin
               cnv_d     = 1'b1;
               cnv_cnt_d = CNT_W'(CNV_CYCLES - 1);
            end
         end
         S_CONVERT: begin
            overrun_evt = trigger_i;
            if (conv_last) begin
               cnv_d     = 1'b0;
               div_cnt_d = DIV_W'(SCK_DIV - 1);
               bit_cnt_d = BIT_W'(DATA_WIDTH);
            end else begin
               cnv_cnt_d = cnv_cnt_q - 1'b1;
            end
         end
         S_SHIFT: begin
            overrun_evt = trigger_i;
            if (sck_tick) begin
               sck_d     = !sck_q;
               div_cnt_d = DIV_W'(SCK_DIV - 1);
               // capture on the edge that drives sck low; ADC updates sdo after that fall
               if (sck_q) begin
                  shift_d   = {shift_q[DATA_WIDTH-2:0], sdo_i};
                  bit_cnt_d = bit_cnt_q - 1'b1;
               end
            end else begin
               div_cnt_d = div_cnt_q - 1'b1;
            end
         end
         S_DONE: begin
            if (out_free) begin
               tdata_d     = shift_q;
               tvalid_d    = 1'b1;
               overrun_evt = trigger_i;
            end else begin
               overrun_evt = 1'b1;
            end
         end
         default: ;
      endcase

      ovr_d = (overrun_evt && (ovr_q != 16'hFFFF)) ? ovr_q + 16'd1 : ovr_q;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         cnv_q     <= 1'b0;
         sck_q     <= 1'b0;
         cnv_cnt_q <= '0;
         div_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         tdata_q   <= '0;
         tvalid_q  <= 1'b0;
         ovr_q     <= '0;
      end else begin
         cnv_q     <= cnv_d;
         sck_q     <= sck_d;
         cnv_cnt_q <= cnv_cnt_d;
         div_cnt_q <= div_cnt_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         tdata_q   <= tdata_d;
         tvalid_q  <= tvalid_d;
         ovr_q     <= ovr_d;
      end
   end

   assign cnv_o           = cnv_q;
   assign sck_o           = sck_q;
   assign m_axis_tdata_o  = tdata_q;
   assign m_axis_tvalid_o = tvalid_q;
   assign overrun_count_o = ovr_q;

endmodule

// File: tb/tb_spi_adc_capture.sv
// tb/tb_spi_adc_capture.sv - randomized and directed bench for spi_adc_capture against a timeline model
module tb_spi_adc_capture;
   localparam int DW        = 8;
   localparam int CNV       = 4;
   localparam int DIV       = 1;
   localparam int SHIFT_LEN = 2 * DIV * DW;
   localparam int DONE_T    = CNV + SHIFT_LEN + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          trigger = 1'b0;
   logic          sdo = 1'b0;
   logic          tready = 1'b0;
   logic          cnv, sck, busy, tvalid;
   logic [DW-1:0] tdata;
   logic [15:0]   ovr;

   spi_adc_capture #(.DATA_WIDTH(DW), .CNV_CYCLES(CNV), .SCK_DIV(DIV)) dut (
      .clk_i(clk), .reset_i(reset), .trigger_i(trigger), .cnv_o(cnv), .sck_o(sck),
      .sdo_i(sdo), .busy_o(busy), .m_axis_tdata_o(tdata), .m_axis_tvalid_o(tvalid),
      .m_axis_tready_i(tready), .overrun_count_o(ovr)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ADC: word latched at cnv rise, MSB presented at cnv fall, next bit after each sck fall
   logic [DW-1:0] adc_next = '0;
   logic [DW-1:0] adc_cur = '0;
   int adc_idx = 0;
   always @(posedge cnv) adc_cur = adc_next;
   always @(negedge cnv) begin
      adc_idx = DW - 1;
      sdo = adc_cur[adc_idx];
   end
   always @(negedge sck) begin
      adc_idx--;
      sdo = (adc_idx >= 0) ? adc_cur[adc_idx] : 1'b0;
   end

   int cyc = 0;
   always @(posedge clk) cyc++;

   // Timeline model: everything follows from edges elapsed since the accepted trigger
   bit            m_active = 1'b0;
   int            m_t = 0;
   logic [DW-1:0] m_word = '0;
   bit            m_valid = 1'b0;
   logic [DW-1:0] m_data = '0;
   int            m_ovr = 0;

   always @(posedge clk or posedge reset) begin
      bit ev;
      bit vpre;
      if (reset) begin
         m_active = 1'b0; m_t = 0; m_valid = 1'b0; m_data = '0; m_ovr = 0;
      end else begin
         ev = 1'b0;
         vpre = m_valid;
         if (vpre && tready) m_valid = 1'b0;
         if (m_active) begin
            m_t++;
            if (trigger) ev = 1'b1;
            if (m_t == DONE_T) begin
               m_active = 1'b0;
               if (!vpre || tready) begin
                  m_valid = 1'b1;
                  m_data = m_word;
               end else begin
                  ev = 1'b1;
               end
            end
         end else if (trigger) begin
            m_active = 1'b1;
            m_t = 0;
            m_word = adc_next;
         end
         if (ev && m_ovr < 65535) m_ovr++;
      end
   end

   function automatic bit exp_cnv();
      return m_active && (m_t < CNV);
   endfunction

   function automatic bit exp_sck();
      if (!m_active || m_t < CNV || m_t >= CNV + SHIFT_LEN) return 1'b0;
      return (((m_t - CNV) / DIV) % 2) == 1;
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         chk("cnv", 32'(cnv), 32'(exp_cnv()));
         chk("sck", 32'(sck), 32'(exp_sck()));
         chk("busy", 32'(busy), 32'(m_active));
         chk("tvalid", 32'(tvalid), 32'(m_valid));
         chk("overrun_count", 32'(ovr), 32'(m_ovr));
         if (m_valid) chk("tdata", 32'(tdata), 32'(m_data));
      end
   end

   task automatic pulse_trigger(input logic [DW-1:0] w);
      adc_next = w;
      trigger = 1'b1;
      @(negedge clk);
      trigger = 1'b0;
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (!tvalid && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_timeout"}, 32'(tvalid), 32'd1);
   endtask

   initial begin
      int t0, cnv_hi, rises, held, samples, ovr0, falls, errs;
      logic sck_prev;
      logic [DW-1:0] rx[$];

      @(negedge clk);
      chk("reset_cnv", 32'(cnv), 32'd0);
      chk("reset_sck", 32'(sck), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_tvalid", 32'(tvalid), 32'd0);
      chk("reset_tdata", 32'(tdata), 32'd0);
      chk("reset_ovr", 32'(ovr), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // basic capture
      tready = 1'b1;
      pulse_trigger(8'hA5);
      t0 = cyc; cnv_hi = 0; rises = 0; sck_prev = 1'b0;
      for (int i = 0; i < 100 && !tvalid; i++) begin
         if (cnv) cnv_hi++;
         if (sck && !sck_prev) rises++;
         sck_prev = sck;
         @(negedge clk);
      end
      chk("basic_tvalid", 32'(tvalid), 32'd1);
      chk("basic_latency", 32'(cyc - t0), 32'd21);
      chk("basic_tdata", 32'(tdata), 32'hA5);
      chk("basic_cnv_cycles", 32'(cnv_hi), 32'd4);
      chk("basic_sck_pulses", 32'(rises), 32'd8);
      @(negedge clk);
      chk("basic_tvalid_1cycle", 32'(tvalid), 32'd0);

      // backpressure
      tready = 1'b0;
      pulse_trigger(8'h3C);
      wait_valid("bp");
      held = 0;
      repeat (50) begin
         if (tvalid && tdata == 8'h3C) held++;
         @(negedge clk);
      end
      chk("bp_held", 32'(held), 32'd50);
      tready = 1'b1;
      @(negedge clk);
      chk("bp_done", 32'(tvalid), 32'd0);
      chk("bp_ovr", 32'(ovr), 32'd0);

      // trigger during conversion
      ovr0 = ovr; cnv_hi = 0; samples = 0;
      adc_next = 8'h5A;
      trigger = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         trigger = (i == 4);
         if (i == 4) adc_next = 8'h77;
         if (cnv) cnv_hi++;
         if (tvalid && tready) samples++;
      end
      trigger = 1'b0;
      chk("dup_samples", 32'(samples), 32'd1);
      chk("dup_ovr", 32'(ovr - ovr0), 32'd1);
      chk("dup_cnv_cycles", 32'(cnv_hi), 32'd4);

      // output full
      tready = 1'b0; ovr0 = ovr;
      adc_next = 8'h11;
      trigger = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         trigger = (i == 29);
         if (i == 29) adc_next = 8'h22;
      end
      trigger = 1'b0;
      chk("full_tdata", 32'(tdata), 32'h11);
      chk("full_tvalid", 32'(tvalid), 32'd1);
      chk("full_ovr", 32'(ovr - ovr0), 32'd1);
      tready = 1'b1;
      @(negedge clk);

      // back-to-back at the minimum period
      ovr0 = ovr;
      for (int k = 0; k < 100; k++) begin
         adc_next = DW'(k + 1);
         trigger = 1'b1;
         for (int j = 0; j < 22; j++) begin
            @(negedge clk);
            trigger = 1'b0;
            if (tvalid && tready) rx.push_back(tdata);
         end
      end
      repeat (30) begin
         @(negedge clk);
         if (tvalid && tready) rx.push_back(tdata);
      end
      chk("b2b_count", 32'(rx.size()), 32'd100);
      errs = 0;
      foreach (rx[k]) if (rx[k] != DW'(k + 1)) errs++;
      chk("b2b_order", 32'(errs), 32'd0);
      chk("b2b_ovr", 32'(ovr - ovr0), 32'd0);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         trigger = ($urandom_range(0, 7) == 0);
         tready = ($urandom_range(0, 2) != 0);
         adc_next = DW'($urandom);
      end
      trigger = 1'b0;

      // reset mid-SHIFT with a held sample in the output register
      tready = 1'b0;
      repeat (30) @(negedge clk);
      pulse_trigger(8'h96);
      wait_valid("rst_pre");
      pulse_trigger(8'h69);
      falls = 0; sck_prev = sck;
      for (int i = 0; i < 100 && falls < 3; i++) begin
         @(negedge clk);
         if (!sck && sck_prev) falls++;
         sck_prev = sck;
      end
      chk("rst_bits_shifted", 32'(falls), 32'd3);
      @(negedge clk);
      #1 reset = 1'b1;
      #1;
      chk("rst_async_cnv", 32'(cnv), 32'd0);
      chk("rst_async_sck", 32'(sck), 32'd0);
      chk("rst_async_busy", 32'(busy), 32'd0);
      chk("rst_async_tvalid", 32'(tvalid), 32'd0);
      chk("rst_async_ovr", 32'(ovr), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      tready = 1'b1;
      @(negedge clk);
      pulse_trigger(8'hC3);
      t0 = cyc;
      wait_valid("rst_post");
      chk("rst_post_latency", 32'(cyc - t0), 32'd21);
      chk("rst_post_tdata", 32'(tdata), 32'hC3);
      repeat (3) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end
endmodule
